// File: rtl/hazard_control_unit.sv
// hazard_control_unit: pipeline hazard detection (load-use, mult/div occupancy) with stall/flush control
//   clk            : single clock, all state updates on the rising edge
//   rst            : synchronous active-low reset
//   id_rs, id_rt   : source registers of the instruction in ID
//   id_usesRs/Rt   : ID instruction actually reads rs / rt
//   id_isMulDiv    : ID instruction is mult/multu/div/divu
//   id_readsHiLo   : ID instruction is mfhi/mflo
//   ex_memRead     : EX instruction is a load
//   ex_regToWrite  : destination register of the EX instruction
//   ex_branchTaken : branch/jump resolved taken in EX this cycle
//   pc_en, ifid_en : PC and IF/ID write enables
//   ifid_flush, idex_flush : bubble insertion into IF/ID, ID/EX
//   md_busy        : mult/div unit occupied
//   stall_count    : saturating count of stall cycles since reset
module hazard_control_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MULDIV_LATENCY = 32,
    parameter int PERF_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_usesRs,
    input  logic                      id_usesRt,
    input  logic                      id_isMulDiv,
    input  logic                      id_readsHiLo,
    input  logic                      ex_memRead,
    input  logic [REG_ADDR_WIDTH-1:0] ex_regToWrite,
    input  logic                      ex_branchTaken,
    output logic                      pc_en,
    output logic                      ifid_en,
    output logic                      ifid_flush,
    output logic                      idex_flush,
    output logic                      md_busy,
    output logic [PERF_WIDTH-1:0]     stall_count
);
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MD_WAIT = 1'b1;
    localparam logic [7:0] MD_LOAD = 8'(MULDIV_LATENCY - 1);

    logic [0:0]            state_q, state_d;
    logic [7:0]            md_cnt_q, md_cnt_d;
    logic [PERF_WIDTH-1:0] stall_count_q, stall_count_d;
    logic                  load_use, md_hazard, stall, issue;

    always_comb begin
        // busy is masked during reset so a held-low rst never reports an old operation
        md_busy   = rst && (state_q == MD_WAIT);
        load_use  = ex_memRead && (ex_regToWrite != '0) &&
                    ((id_usesRs && (id_rs == ex_regToWrite)) ||
                     (id_usesRt && (id_rt == ex_regToWrite)));
        md_hazard = md_busy && (id_isMulDiv || id_readsHiLo);
        // a taken branch discards the ID instruction, so there is nothing to stall
        stall     = rst && (load_use || md_hazard) && !ex_branchTaken;
        issue     = rst && id_isMulDiv && !stall && !ex_branchTaken;
        pc_en      = rst && !stall;
        ifid_en    = rst && !stall;
        ifid_flush = !rst || ex_branchTaken;
        idex_flush = !rst || ex_branchTaken || stall;
        stall_count = stall_count_q;
    end

    always_comb begin
        state_d       = state_q;
        md_cnt_d      = md_cnt_q;
        stall_count_d = (stall && !(&stall_count_q)) ? stall_count_q + PERF_WIDTH'(1) : stall_count_q;
        if (state_q == RUN) begin
            if (issue) begin
                state_d  = MD_WAIT;
                md_cnt_d = MD_LOAD;
            end
        end else if (md_cnt_q != 8'd0) begin
            md_cnt_d = md_cnt_q - 8'd1;
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            md_cnt_q      <= 8'd0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed self-checking bench for hazard_control_unit
module tb_hazard_control_unit;
    localparam int AW = 5;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] id_rs, id_rt, ex_regToWrite;
    logic          id_usesRs, id_usesRt, id_isMulDiv, id_readsHiLo, ex_memRead, ex_branchTaken;
    logic          pc_en, ifid_en, ifid_flush, idex_flush, md_busy;
    logic [PW-1:0] stall_count;
    logic          pc_en_l, ifid_en_l, ifid_flush_l, idex_flush_l, md_busy_l;
    logic [PW-1:0] stall_count_l;

    int checks = 0;
    int errors = 0;
    int exp_sc = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.REG_ADDR_WIDTH(AW), .MULDIV_LATENCY(4), .PERF_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_usesRs(id_usesRs), .id_usesRt(id_usesRt), .id_isMulDiv(id_isMulDiv),
        .id_readsHiLo(id_readsHiLo), .ex_memRead(ex_memRead), .ex_regToWrite(ex_regToWrite),
        .ex_branchTaken(ex_branchTaken), .pc_en(pc_en), .ifid_en(ifid_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .md_busy(md_busy),
        .stall_count(stall_count)
    );

    hazard_control_unit #(.REG_ADDR_WIDTH(AW), .MULDIV_LATENCY(12), .PERF_WIDTH(PW)) dut_l (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_usesRs(id_usesRs), .id_usesRt(id_usesRt), .id_isMulDiv(id_isMulDiv),
        .id_readsHiLo(id_readsHiLo), .ex_memRead(ex_memRead), .ex_regToWrite(ex_regToWrite),
        .ex_branchTaken(ex_branchTaken), .pc_en(pc_en_l), .ifid_en(ifid_en_l),
        .ifid_flush(ifid_flush_l), .idex_flush(idex_flush_l), .md_busy(md_busy_l),
        .stall_count(stall_count_l)
    );

    task automatic idle();
        id_rs = '0; id_rt = '0; ex_regToWrite = '0;
        id_usesRs = 0; id_usesRt = 0; id_isMulDiv = 0; id_readsHiLo = 0;
        ex_memRead = 0; ex_branchTaken = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got pc_en/ifid_en/ifid_flush/idex_flush=%b want %b", name, got, want);
        end
    endtask

    task automatic chk_busy(input string name, input logic want);
        checks++;
        if (md_busy !== want) begin
            errors++;
            $display("FAIL %s: md_busy got %b want %b", name, md_busy, want);
        end
    endtask

    task automatic chk_sc(input string name);
        checks++;
        if (stall_count !== PW'(exp_sc)) begin
            errors++;
            $display("FAIL %s: stall_count got %0d want %0d", name, stall_count, exp_sc);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 0;
        tick(); tick();
        ex_memRead = 1; ex_regToWrite = 5'd8; id_rs = 5'd8; id_usesRs = 1;
        settle();
        chk("reset_outputs", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b0011);
        chk_busy("reset_busy", 1'b0);
        tick();
        exp_sc = 0;
        chk_sc("reset_count_frozen");
        idle();
        rst = 1;
        settle();
        chk("post_reset_run", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b1100);
        tick();
    endtask

    task automatic test_load_use();
        idle();
        ex_memRead = 1; ex_regToWrite = 5'd8; id_rs = 5'd8; id_usesRs = 1;
        settle();
        chk("load_use_rs", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b0001);
        tick();
        exp_sc++;
        chk_sc("load_use_count");
        idle();
        settle();
        chk("load_use_release", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b1100);
        ex_memRead = 1; ex_regToWrite = 5'd17; id_rt = 5'd17; id_usesRt = 1; id_rs = 5'd3; id_usesRs = 1;
        settle();
        chk("load_use_rt", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b0001);
        tick();
        exp_sc++;
        chk_sc("load_use_rt_count");
    endtask

    task automatic test_no_hazard();
        idle();
        ex_memRead = 1; ex_regToWrite = 5'd0; id_rs = 5'd0; id_usesRs = 1;
        settle();
        chk("zero_reg", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b1100);
        tick();
        ex_regToWrite = 5'd8; id_rs = 5'd8; id_usesRs = 0;
        settle();
        chk("rs_unused", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b1100);
        tick();
        ex_memRead = 0; id_usesRs = 1;
        settle();
        chk("not_load", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b1100);
        tick();
        chk_sc("no_hazard_count");
    endtask

    task automatic test_muldiv();
        idle();
        id_isMulDiv = 1;
        settle();
        chk("mult_issue", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b1100);
        chk_busy("mult_issue_busy", 1'b0);
        tick();
        idle();
        id_readsHiLo = 1;
        for (int c = 1; c <= 4; c++) begin
            settle();
            chk_busy($sformatf("mflo_busy_c%0d", c), 1'b1);
            chk($sformatf("mflo_stall_c%0d", c), {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b0001);
            tick();
            exp_sc++;
        end
        settle();
        chk_busy("mflo_free", 1'b0);
        chk("mflo_advance", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b1100);
        chk_sc("mflo_count");
        tick();
    endtask

    task automatic test_back_to_back();
        idle();
        id_isMulDiv = 1;
        tick();
        for (int c = 1; c <= 4; c++) begin
            settle();
            chk($sformatf("b2b_stall_c%0d", c), {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b0001);
            tick();
            exp_sc++;
        end
        settle();
        chk("b2b_issue", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b1100);
        tick();
        idle();
        settle();
        chk_busy("b2b_second_busy", 1'b1);
        chk_sc("b2b_count");
        for (int c = 0; c < 4; c++) tick();
        settle();
        chk_busy("b2b_done", 1'b0);
    endtask

    task automatic test_branch();
        idle();
        ex_memRead = 1; ex_regToWrite = 5'd8; id_rs = 5'd8; id_usesRs = 1; ex_branchTaken = 1;
        settle();
        chk("branch_over_load_use", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b1111);
        tick();
        chk_sc("branch_count");
        idle();
        id_isMulDiv = 1;
        tick();
        idle();
        ex_branchTaken = 1;
        id_readsHiLo = 1;
        settle();
        chk_busy("branch_md_busy", 1'b1);
        chk("branch_in_md_wait", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b1111);
        tick();
        ex_branchTaken = 0;
        for (int c = 2; c <= 4; c++) begin
            settle();
            chk_busy($sformatf("branch_md_busy_c%0d", c), 1'b1);
            tick();
            exp_sc++;
        end
        settle();
        chk_busy("branch_md_done", 1'b0);
        chk_sc("branch_md_count");
        tick();
    endtask

    task automatic test_reset_md();
        idle();
        id_isMulDiv = 1;
        tick();
        idle();
        tick(); tick();
        settle();
        checks++;
        if (md_busy_l !== 1'b1) begin
            errors++;
            $display("FAIL rst_md_pre_busy: md_busy got %b want 1", md_busy_l);
        end
        rst = 0;
        id_readsHiLo = 1;
        settle();
        checks++;
        if ({pc_en_l, ifid_en_l, ifid_flush_l, idex_flush_l, md_busy_l} !== 5'b00110) begin
            errors++;
            $display("FAIL rst_md_low: got %b want 00110",
                     {pc_en_l, ifid_en_l, ifid_flush_l, idex_flush_l, md_busy_l});
        end
        tick();
        rst = 1;
        settle();
        checks++;
        if ({pc_en_l, md_busy_l} !== 2'b10 || stall_count_l !== '0) begin
            errors++;
            $display("FAIL rst_md_after: pc_en/md_busy got %b want 10, stall_count got %0d want 0",
                     {pc_en_l, md_busy_l}, stall_count_l);
        end
        exp_sc = 0;
        chk_sc("rst_md_main_count");
        tick();
        idle();
    endtask

    task automatic test_saturate();
        idle();
        ex_memRead = 1; ex_regToWrite = 5'd9; id_rt = 5'd9; id_usesRt = 1;
        for (int c = 0; c < (1 << PW) + 5; c++) begin
            tick();
            if (exp_sc < (1 << PW) - 1) exp_sc++;
            if (c == 253) chk_sc("sat_254");
        end
        chk_sc("sat_hold");
        settle();
        chk("sat_still_stalling", {pc_en, ifid_en, ifid_flush, idex_flush}, 4'b0001);
        idle();
        tick();
        chk_sc("sat_final");
    endtask

    initial begin
        idle();
        rst = 0;
        tick();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_muldiv();
        test_back_to_back();
        test_branch();
        test_reset_md();
        test_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter MULDIV_LATENCY, default 32, EX-stage cycles occupied by a mult/div (legal range 1..255).
REQ-003 SHALL have parameter PERF_WIDTH, default 16, width of the stall performance counter.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 id_rs, id_rt  input  REG_ADDR_WIDTH each  source registers of the instruction in ID.
REQ-007 id_usesRs, id_usesRt  input  1 each  ID instruction actually reads rs / rt.
REQ-008 id_isMulDiv  input  1  ID instruction is mult/multu/div/divu.
REQ-009 id_readsHiLo  input  1  ID instruction is mfhi/mflo.
REQ-010 ex_memRead  input  1  EX instruction is a load.
REQ-011 ex_regToWrite  input  REG_ADDR_WIDTH  destination register of the EX instruction.
REQ-012 ex_branchTaken  input  1  branch/jump resolved taken in EX this cycle.
REQ-013 pc_en, ifid_en  output  1 each  PC and IF/ID register write enables.
REQ-014 ifid_flush, idex_flush  output  1 each  insert bubble into IF/ID, ID/EX.
REQ-015 md_busy  output  1  mult/div unit occupied.
REQ-016 stall_count  output  PERF_WIDTH  count of stall cycles since reset.

Function
REQ-017 load_use SHALL be 1 when ex_memRead=1, ex_regToWrite!=0 and ((id_usesRs and id_rs==ex_regToWrite) or (id_usesRt and id_rt==ex_regToWrite)).
REQ-018 md_hazard SHALL be 1 when md_busy=1 and (id_isMulDiv=1 or id_readsHiLo=1).
REQ-019 stall SHALL be (load_use or md_hazard) and not ex_branchTaken; evaluation is combinational, zero-cycle latency.
REQ-020 When stall=1: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0.
REQ-021 When ex_branchTaken=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_flush=1, regardless of hazards (wrong-path instruction is discarded, not stalled).
REQ-022 Otherwise (no stall, no branch): pc_en=1, ifid_en=1, both flushes 0.
REQ-023 FSM states SHALL be RUN and MD_WAIT; md_busy=1 exactly in MD_WAIT.
REQ-024 An 8-bit md_cnt SHALL track mult/div occupancy.
REQ-025 issue SHALL be id_isMulDiv=1 and stall=0 and ex_branchTaken=0 (instruction advances into EX).
REQ-026 RUN -> MD_WAIT on issue; md_cnt loads MULDIV_LATENCY-1 (0 for latency 1).
REQ-027 In MD_WAIT with md_cnt!=0: md_cnt decrements by 1 each cycle.
REQ-028 In MD_WAIT with md_cnt==0: next state RUN; md_busy=0 in the following cycle, so a dependent mfhi/mflo issues with exactly MULDIV_LATENCY cycles of occupancy behind the mult/div.
REQ-029 Issue is impossible in MD_WAIT because md_hazard forces stall; a back-to-back mult/div waits until RUN.
REQ-030 ex_branchTaken in MD_WAIT SHALL NOT cancel the in-flight operation (it is already past EX entry); counting continues.
REQ-031 stall_count SHALL increment by 1 on each cycle with stall=1, saturate at all-ones, never wrap.
REQ-032 Simultaneous load_use and md_hazard SHALL count as one stall cycle.

Reset
REQ-033 rst=0 at a rising edge SHALL force state RUN, md_cnt=0, stall_count=0, overriding any in-flight operation.
REQ-034 While rst=0: pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1, md_busy=0; stall_count does not increment.
REQ-035 First cycle after rst returns to 1 SHALL behave as RUN with no history.

Verification
REQ-036 ex_memRead=1, ex_regToWrite=8, id_rs=8, id_usesRs=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_count 0->1; next cycle (ex_memRead=0) all enables 1.
REQ-037 Same as REQ-036 but ex_regToWrite=0, or id_usesRs=0 -> no stall, stall_count unchanged.
REQ-038 MULDIV_LATENCY=4: issue mult at cycle 0, mflo held in ID from cycle 1 -> md_busy=1 cycles 1-4, stall=1 cycles 1-4, mflo advances cycle 5; stall_count=4.
REQ-039 Load-use hazard and ex_branchTaken=1 same cycle -> ifid_flush=1, idex_flush=1, pc_en=1, stall_count unchanged.
REQ-040 rst=0 asserted in MD_WAIT with md_cnt=10 -> next cycle state RUN, md_busy=0, stall_count=0; outputs per REQ-034 while low.
REQ-041 Force 2^PERF_WIDTH+5 stall cycles -> stall_count holds all-ones, no wrap.
